// File: rtl/simon_sequence_player.sv
// Replays the Simon colour sequence on four LEDs. Each step's colour is regenerated
// from the stored seed by an 8-bit Fibonacci LFSR, so no sequence memory is needed.
module simon_sequence_player #(
    parameter int SEQ_LEN    = 32,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] random_num,
    input  logic       seed_load,
    input  logic       play_start,
    input  logic [5:0] round_len,
    input  logic       abort,
    output logic [3:0] led,
    output logic [1:0] color,
    output logic       color_valid,
    output logic       busy,
    output logic       play_done
);

    localparam int PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int LEN_W  = $clog2(SEQ_LEN + 1);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYCLES - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       seed_q;
    logic [7:0]       lfsr_q;
    logic [PH_W-1:0]  phase_q;
    logic [LEN_W-1:0] step_q;
    logic [LEN_W-1:0] len_q;
    logic [3:0]       led_q;
    logic [1:0]       color_q;
    logic             color_valid_q;
    logic             busy_q;
    logic             play_done_q;

    logic [7:0]       seed_in_d;
    logic [7:0]       start_seed_d;
    logic [7:0]       lfsr_next_d;
    logic [LEN_W-1:0] len_d;

    // An all-zero seed would lock the LFSR, so it is stored as 8'h01.
    always_comb begin
        seed_in_d    = (random_num == 8'h00) ? 8'h01 : random_num;
        start_seed_d = seed_load ? seed_in_d : seed_q;
        lfsr_next_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (round_len == 6'd0) begin
            len_d = LEN_W'(1);
        end else if (int'(round_len) > SEQ_LEN) begin
            len_d = LEN_W'(SEQ_LEN);
        end else begin
            len_d = LEN_W'(round_len);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            seed_q        <= 8'h01;
            lfsr_q        <= 8'h01;
            phase_q       <= '0;
            step_q        <= '0;
            len_q         <= '0;
            led_q         <= 4'b0000;
            color_q       <= 2'd0;
            color_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            play_done_q   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each branch only has to raise them.
            color_valid_q <= 1'b0;
            play_done_q   <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                phase_q <= '0;
                led_q   <= 4'b0000;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (seed_load) seed_q <= seed_in_d;
                        if (play_start) begin
                            state_q       <= S_ON;
                            lfsr_q        <= start_seed_d;
                            step_q        <= '0;
                            len_q         <= len_d;
                            phase_q       <= '0;
                            led_q         <= 4'b0001 << start_seed_d[1:0];
                            color_q       <= start_seed_d[1:0];
                            color_valid_q <= 1'b1;
                            busy_q        <= 1'b1;
                        end
                    end
                    S_ON: begin
                        if (phase_q == ON_LAST) begin
                            state_q <= S_OFF;
                            phase_q <= '0;
                            led_q   <= 4'b0000;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                    S_OFF: begin
                        if (phase_q == OFF_LAST) begin
                            phase_q <= '0;
                            if (step_q == len_q - 1'b1) begin
                                state_q     <= S_DONE;
                                play_done_q <= 1'b1;
                            end else begin
                                state_q       <= S_ON;
                                step_q        <= step_q + 1'b1;
                                lfsr_q        <= lfsr_next_d;
                                led_q         <= 4'b0001 << lfsr_next_d[1:0];
                                color_q       <= lfsr_next_d[1:0];
                                color_valid_q <= 1'b1;
                            end
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign led         = led_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign busy        = busy_q;
    assign play_done   = play_done_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Scoreboard bench for simon_sequence_player: a driver queues expected step/done events
// from a reference model, and a negedge monitor pops and compares them as the DUT emits them.
module tb_simon_sequence_player;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int SEQ = 32;
    localparam int PER = ON + OFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] random_num = 8'h00;
    logic       seed_load = 1'b0;
    logic       play_start = 1'b0;
    logic [5:0] round_len = 6'd0;
    logic       abort = 1'b0;
    logic [3:0] led;
    logic [1:0] color;
    logic       color_valid;
    logic       busy;
    logic       play_done;

    simon_sequence_player #(
        .SEQ_LEN   (SEQ),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .random_num (random_num),
        .seed_load  (seed_load),
        .play_start (play_start),
        .round_len  (round_len),
        .abort      (abort),
        .led        (led),
        .color      (color),
        .color_valid(color_valid),
        .busy       (busy),
        .play_done  (play_done)
    );

    always #5 clk = ~clk;

    // cyc holds the index of the most recent rising edge when read at a falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [1:0] col;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         lit_cycles = 0;
    logic [7:0] model_seed = 8'h01;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (led != 4'b0000) begin
                lit_cycles++;
                check("led_matches_color", int'(led), 1 << color);
            end
            if (color_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_color_valid: color %0d at cyc %0d, none expected", color, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("step_kind", int'(e.is_done), 0);
                    check("step_color", int'(color), int'(e.col));
                    check("step_led", int'(led), 1 << e.col);
                    check("step_cycle", cyc, e.at);
                    check("step_busy", int'(busy), 1);
                end
            end
            if (play_done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_play_done: at cyc %0d, none expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", int'(e.is_done), 1);
                    check("done_cycle", cyc, e.at);
                    check("done_busy", int'(busy), 1);
                    check("done_led_dark", int'(led), 0);
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Issues play_start (optionally with seed_load) and queues the events the model
    // predicts; only the first max_steps steps (and done, if all fit) are queued.
    task automatic start_play(input bit do_load, input logic [7:0] rn, input logic [5:0] rl,
                              input int max_steps, output int k, output int len);
        logic [7:0] s;
        @(negedge clk);
        seed_load  = do_load;
        random_num = rn;
        play_start = 1'b1;
        round_len  = rl;
        if (do_load) model_seed = (rn == 8'h00) ? 8'h01 : rn;
        len = (rl == 6'd0) ? 1 : ((int'(rl) > SEQ) ? SEQ : int'(rl));
        k = cyc + 1;
        s = model_seed;
        lit_cycles = 0;
        for (int j = 0; j < len; j++) begin
            if (j < max_steps) exp_q.push_back('{1'b0, s[1:0], k + j * PER});
            s = lfsr_step(s);
        end
        if (max_steps >= len) exp_q.push_back('{1'b1, 2'd0, k + len * PER});
        @(negedge clk);
        seed_load  = 1'b0;
        play_start = 1'b0;
    endtask

    task automatic wait_done(input int len);
        for (int i = 0; i < len * PER + 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("all_events_seen", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("lit_cycles", lit_cycles, len * ON);
        check("idle_busy", int'(busy), 0);
        check("idle_led", int'(led), 0);
    endtask

    task automatic play(input bit do_load, input logic [7:0] rn, input logic [5:0] rl);
        int k, n;
        start_play(do_load, rn, rl, 99, k, n);
        wait_done(n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led"}, int'(led), 0);
        check({tag, "_color"}, int'(color), 0);
        check({tag, "_color_valid"}, int'(color_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_play_done"}, int'(play_done), 0);
    endtask

    initial begin
        int k, n;
        logic [5:0] rl;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Default seed 8'h01: colours 1,2,0,0,1, done 31 cycles after accept.
        play(1'b0, 8'h00, 6'd5);
        // Zero seed behaves like 8'h01.
        play(1'b1, 8'h00, 6'd2);
        // Seed 8'h08 then longer replay of the same seed.
        play(1'b1, 8'h08, 6'd2);
        play(1'b0, 8'h00, 6'd3);
        // Length boundaries: 0 -> 1 step, 40 -> clamped to SEQ.
        play(1'b0, 8'h00, 6'd0);
        play(1'b0, 8'h00, 6'd40);

        // play_start / seed_load during playback are ignored.
        start_play(1'b1, 8'h08, 6'd3, 99, k, n);
        wait_cyc(k + 3);
        play_start = 1'b1;
        seed_load  = 1'b1;
        random_num = 8'h55;
        @(negedge clk);
        play_start = 1'b0;
        seed_load  = 1'b0;
        wait_done(n);
        play(1'b0, 8'h00, 6'd4);

        // Simultaneous seed_load and play_start: new seed used for this round.
        play(1'b1, 8'h04, 6'd2);

        // Abort during step 2 ON.
        start_play(1'b0, 8'h00, 6'd5, 3, k, n);
        wait_cyc(k + 2 * PER + 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_led", int'(led), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_play_done", int'(play_done), 0);
        repeat (3 * PER) @(negedge clk);
        check("abort_events_left", exp_q.size(), 0);
        check("abort_idle_busy", int'(busy), 0);
        exp_q.delete();

        // Abort in IDLE has no effect on a following round.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        play(1'b0, 8'h00, 6'd2);

        // Reset during step 0 OFF: outputs cleared, seed returns to 8'h01.
        start_play(1'b1, 8'h08, 6'd3, 1, k, n);
        wait_cyc(k + ON);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        check("midreset_events_left", exp_q.size(), 0);
        exp_q.delete();
        model_seed = 8'h01;
        play(1'b0, 8'h00, 6'd2);

        // Randomized rounds against the model.
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 7) == 0) rl = 6'($urandom_range(33, 63));
            else rl = 6'($urandom_range(0, 10));
            play(1'($urandom_range(0, 1)), 8'($urandom), rl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simon_sequence_player.md
Name: simon_sequence_player

Overview:
- Reads back the random seed captured at game start and replays the Simon colour sequence on the four game LEDs, one step per timed flash.
- The colour for each step is regenerated from the seed with an 8-bit LFSR on every playback, so no sequence RAM is needed.
- Sits between the RNG capture path and the game controller. The controller requests "play first N steps" and waits for play_done before accepting player input.

Parameters:
- SEQ_LEN, 32: maximum round length (steps); round_len above this is clamped to it.
- ON_CYCLES, 25000000: clock cycles each LED step is lit; minimum 1.
- OFF_CYCLES, 12500000: dark gap cycles after each step; minimum 1.

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- random_num  input  8  random value from the RNG capture path, sampled on seed_load
- seed_load  input  1  1-cycle strobe: latch random_num as the sequence seed
- play_start  input  1  1-cycle strobe: begin playback of round_len steps
- round_len  input  6  number of steps to play, latched on accept
- abort  input  1  stop playback immediately, return to IDLE
- led  output  4  one-hot colour drive, 0 when dark
- color  output  2  colour index of the current step, held through its ON and OFF phases
- color_valid  output  1  1-cycle pulse on the first ON cycle of each step
- busy  output  1  high from the first ON cycle through the DONE cycle
- play_done  output  1  1-cycle pulse after the last step's OFF phase

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - seed=8'h01, FSM=IDLE.
  - led=0, color=0, color_valid=0, busy=0, play_done=0.
  - All counters cleared.
  - Reset mid-playback aborts with no play_done.
- LFSR: Fibonacci, fb = s[7]^s[5]^s[4]^s[3], next = {s[6:0], fb}.
  - Step i colour = bits[1:0] of the state after i advances from the seed; step 0 uses the seed itself.
  - led = 4'b0001 << colour during ON.
- Seed capture: seed_load accepted only in IDLE; ignored while busy.
  - random_num==8'h00 is stored as 8'h01, since the all-zero state locks the LFSR.
- Round length: latched when play_start is accepted.
  - 0 is treated as 1.
  - Values above SEQ_LEN are clamped to SEQ_LEN.
- FSM states: IDLE, ON, OFF, DONE.
  - IDLE: play_start=1 -> ON next cycle. LFSR loaded from seed (or from the new value, if seed_load is in the same cycle; seed_load is applied first). step=0.
  - ON: led lit, color_valid high on first cycle only. After ON_CYCLES cycles -> OFF.
  - OFF: led=0, color held. After OFF_CYCLES cycles:
    - if step==len-1 -> DONE;
    - else step++, LFSR advances once -> ON.
  - DONE: play_done=1, busy=1 for exactly one cycle -> IDLE.
- Timing: if play_start is accepted at edge k:
  - step j is ON for cycles k+1+j*(ON+OFF) through k+j*(ON+OFF)+ON;
  - play_done is high in cycle k+len*(ON+OFF)+1;
  - IDLE resumes the cycle after that.
- Ignored inputs: play_start while not IDLE; seed_load while not IDLE.
- abort: from any non-IDLE state -> IDLE next cycle with led=0, busy=0, no play_done. Ignored in IDLE. Reset takes priority over abort.
- Seed retention: the seed is unchanged by playback; repeated play_start with a larger round_len replays identical leading steps.
- Counter widths: phase counter $clog2(max(ON_CYCLES,OFF_CYCLES)+1); step counter $clog2(SEQ_LEN+1). No wrap-around is reachable.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2, SEQ_LEN=32 unless noted):
- Reset then play_start, round_len=5, no seed_load (seed 8'h01):
  - colours 1,2,0,0,1;
  - led 0010,0100,0001,0001,0010, each lit 4 cycles, dark 2 cycles;
  - exactly 5 color_valid pulses;
  - play_done in cycle k+31.
- seed_load with random_num=8'h00, then round_len=2 -> identical to the seed-8'h01 case: colours 1,2.
- seed_load random_num=8'h08, round_len=2 -> colours 0 (led 0001) then 1 (0x11, led 0010). Repeat with round_len=3 -> first two steps identical.
- round_len=0 -> one step played, play_done at k+7. round_len=40 -> clamped to 32 steps, play_done at k+193.
- Ignored and simultaneous inputs:
  - play_start and seed_load (8'h55) during playback -> ignored, seed unchanged;
  - simultaneous seed_load(8'h04) + play_start in IDLE -> step 0 colour 0, step 1 colour 0 (0x08).
- abort asserted in step 2 ON -> next cycle led=0, busy=0, no play_done. Reset asserted mid-OFF -> all outputs 0 next cycle, seed back to 8'h01.
